ip_uart_txfifo: RTL and testbench
=================================

IP_UART_TXFIFO -- requirements
Module: ip_uart_txfifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_LOG2, default 4, FIFO depth = 2**FIFO_DEPTH_LOG2 bytes (16).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port n_reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port wr_data  input  8  byte to enqueue.
REQ-005 SHALL have port wr_req  input  1  one-cycle push strobe.
REQ-006 SHALL have port full  output  1  FIFO holds 2**FIFO_DEPTH_LOG2 bytes.
REQ-007 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-008 SHALL have port level  output  FIFO_DEPTH_LOG2+1  current byte count.
REQ-009 SHALL have port overflow  output  1  sticky; a push was dropped.
REQ-010 SHALL have port send_data  output  8  byte presented to ip_uart.
REQ-011 SHALL have port send_req  output  1  request to ip_uart.
REQ-012 SHALL have port send_busy  input  1  ip_uart busy.

Function
REQ-013 SHALL store bytes in a circular buffer with FIFO_DEPTH_LOG2-bit read/write pointers that wrap modulo depth.
REQ-014 SHALL accept a push when wr_req=1 and full=0: buffer[wp]<=wr_data, wp+1, level+1, effective next cycle.
REQ-015 SHALL drop a push when wr_req=1 and full=1, leave buffer/pointers unchanged, and set overflow=1 until reset, even if a pop occurs in the same cycle.
REQ-016 SHALL, on simultaneous accepted push and pop, keep level unchanged and advance both pointers.
REQ-017 SHALL derive full, empty from registered level (full=level==depth, empty=level==0).
REQ-018 SHALL implement sender FSM states IDLE, REQ, WAIT_DONE.
REQ-019 IDLE: when empty=0 and send_busy=0, SHALL pop head byte into send_data, set send_req=1, go REQ (pop and send_req visible same next edge).
REQ-020 REQ: SHALL hold send_req=1 and send_data stable until send_busy=1, then send_req<=0, go WAIT_DONE.
REQ-021 WAIT_DONE: SHALL wait for send_busy=0, then go IDLE; send_req stays 0.
REQ-022 SHALL never assert send_req in IDLE or WAIT_DONE; minimum one IDLE cycle between bytes.
REQ-023 SHALL keep send_data unchanged outside IDLE->REQ transitions (holds last byte).
REQ-024 SHALL transmit bytes in exact push order with no loss or duplication when overflow=0.
REQ-025 SHALL ignore send_busy while IDLE with empty=1.

Reset
REQ-026 SHALL, when n_reset=0 at a clock edge, set wp=0, rp=0, level=0, overflow=0, send_data=8'h00, send_req=0, state=IDLE, regardless of state (mid-transfer bytes discarded).
REQ-027 SHALL resulting in outputs after reset: full=0, empty=1, level=0.
REQ-028 SHALL ignore wr_req while n_reset=0; buffer contents need not be cleared.

Structure
REQ-029 SHALL place FSM state encodings (IDLE=2'd0, REQ=2'd1, WAIT_DONE=2'd2) as localparams in shared package/include ip_uart_pkg, shared with ip_uart.
REQ-030 SHALL keep the storage array in one sub-module ip_fifo_ram (simple dual-port, sync write, async read) for BSRAM/SSRAM inference.
REQ-031 SHALL be instantiated in tangcart_msx between the message source and ip_uart (send_data/send_req/send_busy direct).

Verification
REQ-032 Push 'H','E','L','L','O' back-to-back, ip_uart model busy 10 cycles per byte -> send_data sequence 48,45,4C,4C,4F, one send_req assertion each, empty=1 at end.
REQ-033 Push 17 bytes with send_busy held 1 -> level=16, full=1, 17th dropped, overflow=1 stays 1.
REQ-034 Level 16 plus simultaneous push and pop -> push dropped, overflow=1, level=15.
REQ-035 Push 40 bytes interleaved with pops -> pointer wrap, all 40 bytes out in order.
REQ-036 Assert n_reset=0 one cycle while state=REQ with level=5 -> next cycle send_req=0, level=0, empty=1, overflow=0, state IDLE.
REQ-037 Hold send_busy=0 for 5 cycles after send_req -> send_req and send_data stay stable until send_busy=1.

Source files
------------

// File: rtl/ip_uart_pkg.sv
// Shared definitions for ip_uart and its TX FIFO front end.
// Holds the sender FSM state encodings and the byte width.
package ip_uart_pkg;

    localparam int unsigned BYTE_W = 8;

    // Sender FSM encodings, shared with ip_uart
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQ       = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = IDLE,
        ST_REQ       = REQ,
        ST_WAIT_DONE = WAIT_DONE
    } send_state_t;

endpackage

// File: rtl/ip_fifo_ram.sv
// Storage array for the TX FIFO: simple dual-port, synchronous write,
// asynchronous read, no reset so it maps onto block/distributed RAM.
// Ports:
//   clk      - write clock
//   we       - write enable
//   waddr    - write address
//   wdata    - write data
//   raddr    - read address
//   rdata_c  - combinational read data at raddr
module ip_fifo_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port
    assign rdata_c = mem[raddr];

endmodule

// File: rtl/ip_uart_txfifo.sv
// Byte FIFO in front of ip_uart plus the sender FSM that feeds it one
// byte at a time using the send_req / send_busy handshake.
// Ports:
//   clk       - single clock, all logic on posedge
//   n_reset   - synchronous active-low reset
//   wr_data   - byte to enqueue
//   wr_req    - one-cycle push strobe
//   full      - FIFO holds 2**FIFO_DEPTH_LOG2 bytes
//   empty     - FIFO holds 0 bytes
//   level     - current byte count
//   overflow  - sticky: a push was dropped because the FIFO was full
//   send_data - byte presented to ip_uart
//   send_req  - request to ip_uart
//   send_busy - ip_uart busy
module ip_uart_txfifo
    import ip_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic [BYTE_W-1:0]        wr_data,
    input  logic                     wr_req,
    output logic                     full,
    output logic                     empty,
    output logic [FIFO_DEPTH_LOG2:0] level,
    output logic                     overflow,
    output logic [BYTE_W-1:0]        send_data,
    output logic                     send_req,
    input  logic                     send_busy
);

    localparam int unsigned PTR_W   = FIFO_DEPTH_LOG2;
    localparam int unsigned LEVEL_W = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH   = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [BYTE_W-1:0] head_c;
    logic              push_ok_c;
    logic              pop_c;
    logic              ram_we_c;
    send_state_t       state;

    // Flags come straight from the registered level
    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    assign push_ok_c = wr_req && !full;
    assign pop_c     = (state == ST_IDLE) && !empty && !send_busy;
    // Pushes are ignored while reset is held
    assign ram_we_c  = push_ok_c && n_reset;

    ip_fifo_ram #(
        .ADDR_W (PTR_W),
        .DATA_W (BYTE_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_c),
        .waddr   (wp),
        .wdata   (wr_data),
        .raddr   (rp),
        .rdata_c (head_c)
    );

    // Pointers, level, overflow flag and sender FSM
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            send_data <= 8'h00;
            send_req  <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            if (push_ok_c) begin
                wp <= wp + PTR_W'(1);
            end
            if (pop_c) begin
                rp <= rp + PTR_W'(1);
            end
            // A dropped push sets the flag even if a pop frees a slot this cycle
            if (wr_req && full) begin
                overflow <= 1'b1;
            end

            case ({push_ok_c, pop_c})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase

            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        send_data <= head_c;
                        send_req  <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (send_busy) begin
                        send_req <= 1'b0;
                        state    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!send_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    send_req <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_uart_txfifo.sv
// Directed testbench for ip_uart_txfifo with a simple ip_uart busy model
// and a monitor that records send_data on every rising edge of send_req.
module tb_ip_uart_txfifo;

    logic       clk;
    logic       n_reset;
    logic [7:0] wr_data;
    logic       wr_req;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] send_data;
    logic       send_req;
    logic       send_busy;

    logic       man_busy;
    logic       model_en;
    logic       model_busy;
    int         model_len;
    int         model_cnt;
    logic       prev_req;
    logic [7:0] cap_q [$];

    int tests_run;
    int tests_failed;

    logic [7:0] hello [5];

    ip_uart_txfifo #(.FIFO_DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .wr_data   (wr_data),
        .wr_req    (wr_req),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .send_data (send_data),
        .send_req  (send_req),
        .send_busy (send_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign send_busy = model_en ? model_busy : man_busy;

    // ip_uart model: goes busy the cycle after seeing send_req, for model_len cycles
    always @(posedge clk) begin
        if (!model_en) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (!model_busy && send_req) begin
            model_busy <= 1'b1;
            model_cnt  <= model_len;
        end else if (model_busy) begin
            if (model_cnt <= 1) model_busy <= 1'b0;
            else model_cnt <= model_cnt - 1;
        end
    end

    // Record each new request's byte
    always @(posedge clk) begin
        prev_req <= send_req;
        if (send_req && !prev_req) cap_q.push_back(send_data);
    end

    task automatic do_reset();
        n_reset = 1'b0;
        wr_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_req  = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_req  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL reset_level got %0d want 0", level); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b want 0", full); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b want 1", empty); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
        tests_run++; if (send_req !== 1'b0) begin tests_failed++; $display("FAIL reset_send_req got %b want 0", send_req); end
        tests_run++; if (send_data !== 8'h00) begin tests_failed++; $display("FAIL reset_send_data got %h want 00", send_data); end
    endtask

    task automatic test_hello();
        int base;
        int cyc;
        do_reset();
        model_len = 10;
        model_en  = 1'b1;
        base = cap_q.size();
        for (int i = 0; i < 5; i++) push(hello[i]);
        cyc = 0;
        while (!(cap_q.size() - base == 5 && empty && !send_req && !send_busy) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++; if (cyc >= 400) begin tests_failed++; $display("FAIL hello_timeout got %0d bytes want 5", cap_q.size() - base); end
        repeat (30) @(negedge clk);
        tests_run++; if (cap_q.size() - base != 5) begin tests_failed++; $display("FAIL hello_count got %0d want 5", cap_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (base + i >= cap_q.size() || cap_q[base + i] !== hello[i]) begin
                tests_failed++;
                $display("FAIL hello_byte%0d got %h want %h", i, (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx, hello[i]);
            end
        end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL hello_empty got %b want 1", empty); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL hello_overflow got %b want 0", overflow); end
        model_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int base;
        int cyc;
        logic [7:0] exp;
        do_reset();
        model_en = 1'b0;
        man_busy = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(8'hA0 + i));
        tests_run++; if (level !== 5'd16) begin tests_failed++; $display("FAIL ovf_level got %0d want 16", level); end
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full got %b want 1", full); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", overflow); end
        tests_run++; if (send_req !== 1'b0) begin tests_failed++; $display("FAIL ovf_no_req got %b want 0", send_req); end
        repeat (3) @(negedge clk);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        // Push and pop in the same cycle while full
        base     = cap_q.size();
        wr_req   = 1'b1;
        wr_data  = 8'hEE;
        man_busy = 1'b0;
        @(negedge clk);
        wr_req   = 1'b0;
        tests_run++; if (level !== 5'd15) begin tests_failed++; $display("FAIL pushpop_level got %0d want 15", level); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL pushpop_overflow got %b want 1", overflow); end
        tests_run++; if (send_req !== 1'b1 || send_data !== 8'hA0) begin tests_failed++; $display("FAIL pushpop_send got req=%b data=%h want req=1 data=a0", send_req, send_data); end
        model_len = 10;
        model_en  = 1'b1;
        cyc = 0;
        while (!(cap_q.size() - base == 16 && empty && !send_req && !send_busy) && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++; if (cyc >= 600) begin tests_failed++; $display("FAIL ovf_drain_timeout got %0d bytes want 16", cap_q.size() - base); end
        repeat (30) @(negedge clk);
        tests_run++; if (cap_q.size() - base != 16) begin tests_failed++; $display("FAIL ovf_drain_count got %0d want 16", cap_q.size() - base); end
        for (int i = 0; i < 16; i++) begin
            exp = 8'(8'hA0 + i);
            tests_run++;
            if (base + i >= cap_q.size() || cap_q[base + i] !== exp) begin
                tests_failed++;
                $display("FAIL ovf_byte%0d got %h want %h", i, (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx, exp);
            end
        end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_after_drain got %b want 1", overflow); end
        model_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_transfer();
        // Overflow is still set from the previous test and must clear here
        man_busy = 1'b1;
        model_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
        man_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (send_req !== 1'b1 || level !== 5'd5) begin tests_failed++; $display("FAIL mid_pre got req=%b level=%0d want req=1 level=5", send_req, level); end
        tests_run++; if (send_data !== 8'h30) begin tests_failed++; $display("FAIL mid_pre_data got %h want 30", send_data); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_overflow got %b want 1", overflow); end
        // One-cycle reset with a push attempted during it
        n_reset = 1'b0;
        wr_req  = 1'b1;
        wr_data = 8'h99;
        @(negedge clk);
        n_reset = 1'b1;
        wr_req  = 1'b0;
        tests_run++; if (send_req !== 1'b0) begin tests_failed++; $display("FAIL mid_send_req got %b want 0", send_req); end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL mid_level got %0d want 0", level); end
        tests_run++; if (empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("FAIL mid_flags got empty=%b full=%b want 1 0", empty, full); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_overflow got %b want 0", overflow); end
        tests_run++; if (send_data !== 8'h00) begin tests_failed++; $display("FAIL mid_send_data got %h want 00", send_data); end
        @(negedge clk);
        tests_run++; if (send_req !== 1'b0 || level !== 5'd0) begin tests_failed++; $display("FAIL mid_idle got req=%b level=%0d want 0 0", send_req, level); end
    endtask

    task automatic test_hold();
        // Continues from the reset state with send_busy low
        push(8'h5A);
        @(negedge clk);
        tests_run++; if (send_req !== 1'b1 || send_data !== 8'h5A) begin tests_failed++; $display("FAIL hold_start got req=%b data=%h want 1 5a", send_req, send_data); end
        tests_run++; if (level !== 5'd0) begin tests_failed++; $display("FAIL hold_level got %0d want 0", level); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (send_req !== 1'b1 || send_data !== 8'h5A) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d got req=%b data=%h want 1 5a", i, send_req, send_data);
            end
        end
        man_busy = 1'b1;
        @(negedge clk);
        tests_run++; if (send_req !== 1'b0 || send_data !== 8'h5A) begin tests_failed++; $display("FAIL hold_ack got req=%b data=%h want 0 5a", send_req, send_data); end
        repeat (2) @(negedge clk);
        tests_run++; if (send_req !== 1'b0) begin tests_failed++; $display("FAIL hold_wait got req=%b want 0", send_req); end
        man_busy = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (send_req !== 1'b0 || empty !== 1'b1 || send_data !== 8'h5A) begin tests_failed++; $display("FAIL hold_end got req=%b empty=%b data=%h want 0 1 5a", send_req, empty, send_data); end
    endtask

    task automatic test_wrap();
        int base;
        int cyc;
        logic [7:0] exp;
        do_reset();
        model_len = 2;
        model_en  = 1'b1;
        base = cap_q.size();
        for (int i = 0; i < 40; i++) begin
            push(8'(i * 37 + 5));
            repeat (5) @(negedge clk);
        end
        cyc = 0;
        while (!(cap_q.size() - base == 40 && empty && !send_req && !send_busy) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++; if (cyc >= 400) begin tests_failed++; $display("FAIL wrap_timeout got %0d bytes want 40", cap_q.size() - base); end
        repeat (10) @(negedge clk);
        tests_run++; if (cap_q.size() - base != 40) begin tests_failed++; $display("FAIL wrap_count got %0d want 40", cap_q.size() - base); end
        for (int i = 0; i < 40; i++) begin
            exp = 8'(i * 37 + 5);
            tests_run++;
            if (base + i >= cap_q.size() || cap_q[base + i] !== exp) begin
                tests_failed++;
                $display("FAIL wrap_byte%0d got %h want %h", i, (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx, exp);
            end
        end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL wrap_overflow got %b want 0", overflow); end
        model_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
        n_reset   = 1'b0;
        wr_req    = 1'b0;
        wr_data   = 8'h00;
        man_busy  = 1'b0;
        model_en  = 1'b0;
        model_len = 10;
        @(negedge clk);
        test_reset();
        test_hello();
        test_overflow();
        test_reset_mid_transfer();
        test_hold();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
